// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Optional feature macro: SIGNED_RESULT_EN (two's-complement input, sign reported on neg).
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 9,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  neg
);

  localparam int unsigned SW = (DIGITS + 1) * 4;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_shift;
  logic [BIN_W-1:0]   w_load;
  logic [SW-1:0]      r_scratch;
  logic [SW-1:0]      w_adj;
  logic [SW:0]        w_cat;
  logic [CW-1:0]      r_cnt;
  logic [DIGITS*4-1:0] r_bcd;
  logic               r_ovf;
  logic               w_accept;
  logic               w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == CW'(1));

  always_comb begin
    w_adj = r_scratch;
    for (int unsigned d = 0; d < DIGITS + 1; d++) begin
      if (r_scratch[d*4 +: 4] >= 4'd5)
        w_adj[d*4 +: 4] = r_scratch[d*4 +: 4] + 4'd3;
    end
  end

  // Bit SW is whatever falls out of the scratch; it counts toward overflow.
  assign w_cat = {w_adj, r_shift[BIN_W-1]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:              w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= w_load;
      r_scratch <= '0;
      r_cnt     <= CW'(BIN_W);
    end else if (r_state == S_SHIFT) begin
      r_shift   <= r_shift << 1;
      r_scratch <= w_cat[SW-1:0];
      r_cnt     <= r_cnt - CW'(1);
      if (w_last) begin
        if (|w_cat[SW -: 5]) begin
          r_bcd <= {DIGITS{4'h9}};
          r_ovf <= 1'b1;
        end else begin
          r_bcd <= w_cat[DIGITS*4-1:0];
          r_ovf <= 1'b0;
        end
      end
    end
  end

`ifdef SIGNED_RESULT_EN
  logic r_neg;
  logic r_neg_pend;

  // Most negative input negates to itself, which reads as the unsigned magnitude 2^(BIN_W-1).
  assign w_load = bin_in[BIN_W-1] ? (~bin_in + BIN_W'(1)) : bin_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg      <= 1'b0;
      r_neg_pend <= 1'b0;
    end else if (w_accept) begin
      r_neg_pend <= bin_in[BIN_W-1];
    end else if ((r_state == S_SHIFT) && w_last) begin
      r_neg      <= r_neg_pend;
    end
  end

  assign neg = r_neg;
`else
  assign w_load = bin_in;
  assign neg    = 1'b0;
`endif

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign bcd_out = r_bcd;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 9-bit/3-digit instance and a 10-bit/3-digit instance for overflow.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start9,  start10;
  logic [8:0]  bin9;
  logic [9:0]  bin10;
  logic        busy9,  busy10;
  logic        done9,  done10;
  logic [11:0] bcd9,   bcd10;
  logic        ovf9,   ovf10;
  logic        neg9,   neg10;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  bit          r_wide = 1'b0;
  logic        m_busy, m_done, m_ovf, m_neg;
  logic [11:0] m_bcd;

  assign m_busy = r_wide ? busy10 : busy9;
  assign m_done = r_wide ? done10 : done9;
  assign m_bcd  = r_wide ? bcd10  : bcd9;
  assign m_ovf  = r_wide ? ovf10  : ovf9;
  assign m_neg  = r_wide ? neg10  : neg9;

  bin2bcd_seq #(.BIN_W(9), .DIGITS(3)) u_dut9 (
    .clk(clk), .rst(rst), .start(start9), .bin_in(bin9),
    .busy(busy9), .done(done9), .bcd_out(bcd9), .ovf(ovf9), .neg(neg9)
  );

  bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) u_dut10 (
    .clk(clk), .rst(rst), .start(start10), .bin_in(bin10),
    .busy(busy10), .done(done10), .bcd_out(bcd10), .ovf(ovf10), .neg(neg10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain division; saturate to 999 above the 3-digit range.
  function automatic void model(input int unsigned v, input int unsigned w,
                                output logic [11:0] bcd, output logic o_ovf, output logic o_neg);
    int unsigned mag;
    mag   = v;
    o_neg = 1'b0;
`ifdef SIGNED_RESULT_EN
    if (v >= (32'd1 << (w - 1))) begin
      mag   = (32'd1 << w) - v;
      o_neg = 1'b1;
    end
`endif
    if (mag > 999) begin
      bcd   = 12'h999;
      o_ovf = 1'b1;
    end else begin
      bcd   = 12'(((mag / 100) << 8) | (((mag / 10) % 10) << 4) | (mag % 10));
      o_ovf = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input int unsigned v);
    if (r_wide) begin start10 = s; bin10 = 10'(v); end
    else        begin start9  = s; bin9  = 9'(v);  end
  endtask

  task automatic run_conv(input bit wide, input int unsigned v, input string name);
    logic [11:0] e_bcd;
    logic        e_ovf, e_neg;
    int unsigned cyc;
    int unsigned bw;
    bw     = wide ? 10 : 9;
    r_wide = wide;
    model(v, bw, e_bcd, e_ovf, e_neg);
    drive(1'b1, v);
    tick();
    drive(1'b0, $urandom);
    vectors++;
    if (m_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start: got %b want 1", name, m_busy);
    end
    cyc = 0;
    while (m_done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    vectors++;
    if (cyc !== bw) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, bw);
    end
    vectors++;
    if (m_bcd !== e_bcd || m_ovf !== e_ovf || m_neg !== e_neg) begin
      miscompares++;
      $display("FAIL %s result(v=%0d): got bcd=%h ovf=%b neg=%b want bcd=%h ovf=%b neg=%b",
               name, v, m_bcd, m_ovf, m_neg, e_bcd, e_ovf, e_neg);
    end
    tick();
    vectors++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_bcd !== e_bcd || m_ovf !== e_ovf) begin
      miscompares++;
      $display("FAIL %s after_done: got done=%b busy=%b bcd=%h ovf=%b want done=0 busy=0 bcd=%h ovf=%b",
               name, m_done, m_busy, m_bcd, m_ovf, e_bcd, e_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start9 = 1'b0; start10 = 1'b0; bin9 = '0; bin10 = '0;
    repeat (3) tick();
    vectors++;
    if ({busy9, done9, bcd9, ovf9, neg9, busy10, done10, bcd10, ovf10, neg10} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h ovf=%b neg=%b want all zero",
               busy9, done9, bcd9, ovf9, neg9);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    int unsigned vals[5] = '{255, 0, 511, 256, 1};
    foreach (vals[i]) run_conv(1'b0, vals[i], "directed");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) run_conv(1'b0, $urandom_range(511, 0), "random9");
  endtask

  task automatic test_busy_ignore();
    logic [11:0] e_bcd;
    logic        e_ovf, e_neg;
    int unsigned pulses;
    r_wide = 1'b0;
    model(100, 9, e_bcd, e_ovf, e_neg);
    drive(1'b1, 100);
    tick();
    drive(1'b0, 42);
    pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      start9 = (k == 3 || k == 10);
      bin9   = 9'd42;
      tick();
      if (done9 === 1'b1) pulses++;
    end
    start9 = 1'b0;
    vectors++;
    if (pulses !== 1 || bcd9 !== e_bcd) begin
      miscompares++;
      $display("FAIL busy_ignore: got pulses=%0d bcd=%h want pulses=1 bcd=%h", pulses, bcd9, e_bcd);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned v, gap, cyc;
    logic [11:0] e_bcd;
    logic        e_ovf, e_neg;
    r_wide = 1'b0;
    v = $urandom_range(511, 0);
    drive(1'b1, v);
    for (int n = 0; n < 4; n++) begin
      model(v, 9, e_bcd, e_ovf, e_neg);
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (done9 !== 1'b1 && cyc < 30);
      gap = (n == 0) ? 10 : 11;
      vectors++;
      if (cyc !== gap || bcd9 !== e_bcd || ovf9 !== e_ovf) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got gap=%0d bcd=%h ovf=%b want gap=%0d bcd=%h ovf=%b",
                 n, cyc, bcd9, ovf9, gap, e_bcd, e_ovf);
      end
      v    = $urandom_range(511, 0);
      bin9 = 9'(v);
    end
    start9 = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset_mid();
    int unsigned pulses;
    run_conv(1'b0, 300, "pre_reset");
    r_wide = 1'b0;
    drive(1'b1, 123);
    tick();
    drive(1'b0, 0);
    repeat (4) tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (busy9 !== 1'b0 || done9 !== 1'b0 || bcd9 !== 12'h000 || ovf9 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b bcd=%h ovf=%b want 0 0 000 0",
               busy9, done9, bcd9, ovf9);
    end
    tick();
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done9 === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: got %0d done pulses want 0", pulses);
    end
    run_conv(1'b0, 7, "post_reset");
  endtask

  task automatic test_overflow();
    int unsigned vals[4] = '{1000, 999, 1023, 500};
    foreach (vals[i]) run_conv(1'b1, vals[i], "ovf10");
    for (int i = 0; i < 8; i++) run_conv(1'b1, $urandom_range(1023, 0), "random10");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
